l3_port_arbiter: RTL and testbench

//  Shares the single L3 port among NUM_REQ L2 cache FSMs (L2a..L2d): read_from_L3_request / write_back_to_L3_request.

---
 rtl/l3_port_arbiter_if.sv | 43 ++++
 rtl/l3_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_l3_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l3_port_arbiter_if.sv
// Bundle of L2-side and L3-side signals of the L3 port arbiter.
// master = arbiter view, slave = surrounding L2/L3 environment view.
interface l3_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128
) ();
  localparam int GID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        l2_rd_req;
  logic [NUM_REQ-1:0]        l2_wb_req;
  logic [NUM_REQ*ADDR_W-1:0] l2_addr;
  logic [NUM_REQ*LINE_W-1:0] l2_wb_data;
  logic [NUM_REQ-1:0]        l2_rd_done;
  logic [NUM_REQ-1:0]        l2_wb_done;
  logic [LINE_W-1:0]         l2_rd_data;
  logic                      l3_rd_req;
  logic                      l3_wb_req;
  logic [ADDR_W-1:0]         l3_addr;
  logic [LINE_W-1:0]         l3_wb_data;
  logic                      L3_ready;
  logic [LINE_W-1:0]         l3_rd_data;
  logic                      write_back_to_L3_verified;
  logic [GID_W-1:0]          grant_id;
  logic                      busy;
  logic                      timeout_err;

  modport master (
    input  l2_rd_req, l2_wb_req, l2_addr, l2_wb_data,
    input  L3_ready, l3_rd_data, write_back_to_L3_verified,
    output l2_rd_done, l2_wb_done, l2_rd_data,
    output l3_rd_req, l3_wb_req, l3_addr, l3_wb_data,
    output grant_id, busy, timeout_err
  );

  modport slave (
    output l2_rd_req, l2_wb_req, l2_addr, l2_wb_data,
    output L3_ready, l3_rd_data, write_back_to_L3_verified,
    input  l2_rd_done, l2_wb_done, l2_rd_data,
    input  l3_rd_req, l3_wb_req, l3_addr, l3_wb_data,
    input  grant_id, busy, timeout_err
  );
endinterface

// File: rtl/l3_port_arbiter.sv
// Round-robin arbiter sharing one L3 port among NUM_REQ L2 caches,
// one outstanding transaction at a time, with registered outputs and a BUSY timeout.
module l3_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset,
  l3_port_arbiter_if.master bus
);
  localparam int GID_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t             state_reg, state_next;
  logic [GID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic               mask_reg, mask_next;
  logic [GID_W-1:0]   grant_id_reg, grant_id_next;
  logic               op_wb_reg, op_wb_next;
  logic [ADDR_W-1:0]  l3_addr_reg, l3_addr_next;
  logic [LINE_W-1:0]  l3_wb_data_reg, l3_wb_data_next;
  logic               l3_rd_req_reg, l3_rd_req_next;
  logic               l3_wb_req_reg, l3_wb_req_next;
  logic [NUM_REQ-1:0] rd_done_reg, rd_done_next;
  logic [NUM_REQ-1:0] wb_done_reg, wb_done_next;
  logic [LINE_W-1:0]  rd_data_reg, rd_data_next;
  logic               busy_reg, busy_next;
  logic               timeout_err_reg, timeout_err_next;
  logic [CNT_W-1:0]   tmo_cnt_reg, tmo_cnt_next;

  // The previous grantee is excluded for the single IDLE cycle after RELEASE.
  logic [NUM_REQ-1:0] req_eligible;
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_eligible[gi] = (bus.l2_rd_req[gi] | bus.l2_wb_req[gi]) &
                                ~(mask_reg && (grant_id_reg == GID_W'(gi)));
    end
  endgenerate

  logic             win_found;
  logic [GID_W-1:0] win_idx;
  logic [GID_W-1:0] cand_idx;

  // Scan from the farthest offset down so the closest requester to rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_reg;
    cand_idx  = rr_ptr_reg;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_idx = rr_ptr_reg + GID_W'(k);
      if (req_eligible[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  logic done_hit;
  logic tmo_hit;
  assign done_hit = op_wb_reg ? bus.write_back_to_L3_verified : bus.L3_ready;
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) &&
                    ((32'(tmo_cnt_reg) + 32'd1) == 32'(TIMEOUT_CYCLES));

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    mask_next        = 1'b0;
    grant_id_next    = grant_id_reg;
    op_wb_next       = op_wb_reg;
    l3_addr_next     = l3_addr_reg;
    l3_wb_data_next  = l3_wb_data_reg;
    l3_rd_req_next   = l3_rd_req_reg;
    l3_wb_req_next   = l3_wb_req_reg;
    rd_done_next     = '0;
    wb_done_next     = '0;
    rd_data_next     = rd_data_reg;
    busy_next        = busy_reg;
    timeout_err_next = timeout_err_reg;
    tmo_cnt_next     = tmo_cnt_reg;

    unique case (state_reg)
      IDLE: begin
        if (win_found) begin
          grant_id_next   = win_idx;
          op_wb_next      = bus.l2_wb_req[win_idx];
          l3_addr_next    = bus.l2_addr[win_idx*ADDR_W +: ADDR_W];
          l3_wb_data_next = bus.l2_wb_data[win_idx*LINE_W +: LINE_W];
          l3_wb_req_next  = bus.l2_wb_req[win_idx];
          l3_rd_req_next  = ~bus.l2_wb_req[win_idx];
          busy_next       = 1'b1;
          tmo_cnt_next    = '0;
          state_next      = BUSY;
        end
      end
      BUSY: begin
        tmo_cnt_next = (&tmo_cnt_reg) ? tmo_cnt_reg : tmo_cnt_reg + CNT_W'(1);
        if (done_hit) begin
          l3_rd_req_next = 1'b0;
          l3_wb_req_next = 1'b0;
          if (op_wb_reg) begin
            wb_done_next[grant_id_reg] = 1'b1;
          end else begin
            rd_done_next[grant_id_reg] = 1'b1;
            rd_data_next               = bus.l3_rd_data;
          end
          state_next = RELEASE;
        end else if (tmo_hit) begin
          l3_rd_req_next   = 1'b0;
          l3_wb_req_next   = 1'b0;
          timeout_err_next = 1'b1;
          state_next       = RELEASE;
        end
      end
      RELEASE: begin
        rr_ptr_next  = grant_id_reg + GID_W'(1);
        tmo_cnt_next = '0;
        mask_next    = 1'b1;
        busy_next    = 1'b0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      mask_reg        <= 1'b0;
      grant_id_reg    <= '0;
      op_wb_reg       <= 1'b0;
      l3_addr_reg     <= '0;
      l3_wb_data_reg  <= '0;
      l3_rd_req_reg   <= 1'b0;
      l3_wb_req_reg   <= 1'b0;
      rd_done_reg     <= '0;
      wb_done_reg     <= '0;
      rd_data_reg     <= '0;
      busy_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      tmo_cnt_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      mask_reg        <= mask_next;
      grant_id_reg    <= grant_id_next;
      op_wb_reg       <= op_wb_next;
      l3_addr_reg     <= l3_addr_next;
      l3_wb_data_reg  <= l3_wb_data_next;
      l3_rd_req_reg   <= l3_rd_req_next;
      l3_wb_req_reg   <= l3_wb_req_next;
      rd_done_reg     <= rd_done_next;
      wb_done_reg     <= wb_done_next;
      rd_data_reg     <= rd_data_next;
      busy_reg        <= busy_next;
      timeout_err_reg <= timeout_err_next;
      tmo_cnt_reg     <= tmo_cnt_next;
    end
  end

  assign bus.l2_rd_done  = rd_done_reg;
  assign bus.l2_wb_done  = wb_done_reg;
  assign bus.l2_rd_data  = rd_data_reg;
  assign bus.l3_rd_req   = l3_rd_req_reg;
  assign bus.l3_wb_req   = l3_wb_req_reg;
  assign bus.l3_addr     = l3_addr_reg;
  assign bus.l3_wb_data  = l3_wb_data_reg;
  assign bus.grant_id    = grant_id_reg;
  assign bus.busy        = busy_reg;
  assign bus.timeout_err = timeout_err_reg;
endmodule

// File: tb/tb_l3_port_arbiter.sv
// Bench for l3_port_arbiter: directed scenarios then random traffic, checked
// against a transaction-level model of round-robin arbitration.
module tb_l3_port_arbiter;
  localparam int NUM_REQ        = 4;
  localparam int ADDR_W         = 32;
  localparam int LINE_W         = 128;
  localparam int TIMEOUT_CYCLES = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l3_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  l3_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: pending request per L2, rotation start, one-cycle exclusion of last grantee.
  bit                m_rd   [NUM_REQ];
  bit                m_wb   [NUM_REQ];
  logic [ADDR_W-1:0] m_addr [NUM_REQ];
  logic [LINE_W-1:0] m_data [NUM_REQ];
  int                m_rr;
  bit                m_mask_act;
  int                m_mask_id;
  bit                m_terr;
  int                deferred;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.l2_rd_req[i] = m_rd[i];
      bus.l2_wb_req[i] = m_wb[i];
      bus.l2_addr[i*ADDR_W +: ADDR_W]    = m_addr[i];
      bus.l2_wb_data[i*LINE_W +: LINE_W] = m_data[i];
    end
  endtask

  task automatic set_req(input int i, input bit rd, input bit wb, input logic [ADDR_W-1:0] a);
    m_rd[i]   = rd;
    m_wb[i]   = wb;
    m_addr[i] = a;
    m_data[i] = rand_line();
    drive_reqs();
  endtask

  // Called in the cycle where the arbiter may grant; returns after the masked IDLE cycle.
  task automatic run_txn(input int delay, input bit hold, output int won);
    int w;
    int c;
    bit extra;
    bit wb;
    logic [LINE_W-1:0] rdata;
    logic [NUM_REQ-1:0] onehot;
    w = -1;
    extra = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (m_rr + k) % NUM_REQ;
      if (w < 0 && (m_rd[c] || m_wb[c]) && !(m_mask_act && c == m_mask_id)) w = c;
    end
    if (w < 0 && m_mask_act && (m_rd[m_mask_id] || m_wb[m_mask_id])) begin
      w = m_mask_id;
      extra = 1;
    end
    won = w;
    if (w < 0) return;
    wb = m_wb[w];
    onehot = '0;
    onehot[w] = 1'b1;

    step();
    if (deferred >= 0) begin
      m_rd[deferred] = 0;
      m_wb[deferred] = 0;
      deferred = -1;
      drive_reqs();
    end
    m_mask_act = 0;
    if (extra) begin
      chk("masked_idle_req", {bus.l3_rd_req, bus.l3_wb_req}, 2'b00);
      step();
    end
    chk("grant_id", bus.grant_id, w);
    chk("l3_req_op", {bus.l3_rd_req, bus.l3_wb_req}, {!wb, wb});
    chk("l3_addr", bus.l3_addr, m_addr[w]);
    chk("l3_wb_data", bus.l3_wb_data, m_data[w]);
    chk("busy_in_busy", bus.busy, 1'b1);

    for (int j = 0; j < delay; j++) begin
      if (wb) bus.L3_ready = 1'($urandom_range(0, 1));
      else    bus.write_back_to_L3_verified = 1'($urandom_range(0, 1));
      bus.l3_rd_data = rand_line();
      step();
      chk("l3_req_hold", {bus.l3_rd_req, bus.l3_wb_req}, {!wb, wb});
      chk("no_early_done", {bus.l2_rd_done, bus.l2_wb_done}, '0);
    end
    rdata = rand_line();
    bus.l3_rd_data = rdata;
    bus.L3_ready = !wb;
    bus.write_back_to_L3_verified = wb;
    step();
    bus.L3_ready = 0;
    bus.write_back_to_L3_verified = 0;
    chk("rd_done", bus.l2_rd_done, wb ? '0 : onehot);
    chk("wb_done", bus.l2_wb_done, wb ? onehot : '0);
    chk("l3_req_drop", {bus.l3_rd_req, bus.l3_wb_req}, 2'b00);
    if (!wb) chk("rd_data", bus.l2_rd_data, rdata);
    chk("busy_in_release", bus.busy, 1'b1);
    chk("timeout_err", bus.timeout_err, m_terr);
    $display("txn: L2#%0d op=%s addr=0x%08h delay=%0d", w, wb ? "wb" : "rd", m_addr[w], delay);

    step();
    chk("done_one_cycle", {bus.l2_rd_done, bus.l2_wb_done}, '0);
    chk("busy_idle", bus.busy, 1'b0);
    m_rr = (w + 1) % NUM_REQ;
    m_mask_act = 1;
    m_mask_id = w;
    if (hold) begin
      deferred = w;
    end else begin
      if (wb) m_wb[w] = 0;
      else    m_rd[w] = 0;
      drive_reqs();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int won;
    int cnt;
    bit any;
    reset = 1;
    bus.L3_ready = 0;
    bus.write_back_to_L3_verified = 0;
    bus.l3_rd_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      m_rd[i] = 0; m_wb[i] = 0; m_addr[i] = '0; m_data[i] = '0;
    end
    drive_reqs();
    m_rr = 0; m_mask_act = 0; m_mask_id = 0; m_terr = 0; deferred = -1;
    repeat (3) step();
    chk("rst_ctrl", {bus.l3_rd_req, bus.l3_wb_req, bus.busy, bus.timeout_err, bus.grant_id}, '0);
    chk("rst_done", {bus.l2_rd_done, bus.l2_wb_done}, '0);
    chk("rst_addr", bus.l3_addr, '0);
    chk("rst_rd_data", bus.l2_rd_data, '0);
    reset = 0;
    step();

    // Single read from L2#2, L3 answers 3 cycles after the request.
    set_req(2, 1, 0, 32'h8000_0040);
    run_txn(3, 0, won);
    chk("t1_grantee", bus.grant_id, 2);

    // L2#1 asks for write-back and read together: write-back first, read later.
    set_req(1, 1, 1, 32'hC000_1000);
    run_txn(1, 0, won);
    run_txn(0, 0, won);
    chk("t3_read_later", bus.grant_id, 1);

    // Grantee L2#2 holds its request one cycle past done; L2#3 must win next.
    set_req(2, 1, 0, 32'h4000_0200);
    m_rd[3] = 1; m_addr[3] = 32'h4000_0300; m_data[3] = rand_line();
    drive_reqs();
    run_txn(1, 1, won);
    run_txn(2, 0, won);
    chk("t6_other_wins", bus.grant_id, 3);

    // L3 never answers a write-back from L2#1.
    set_req(1, 0, 1, 32'h0000_0880);
    step();
    m_mask_act = 0;
    chk("t4_grant", bus.grant_id, 1);
    cnt = 0;
    while (bus.l3_wb_req === 1'b1 && cnt < 300) begin
      cnt++;
      chk("t4_no_done", {bus.l2_rd_done, bus.l2_wb_done}, '0);
      bus.L3_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.L3_ready = 0;
    chk("t4_busy_cycles", cnt, TIMEOUT_CYCLES);
    chk("t4_timeout_err", bus.timeout_err, 1'b1);
    chk("t4_no_done_release", {bus.l2_rd_done, bus.l2_wb_done}, '0);
    m_terr = 1;
    step();
    chk("t4_sticky", bus.timeout_err, 1'b1);
    m_rr = 2; m_mask_act = 1; m_mask_id = 1;
    m_wb[1] = 0;
    set_req(0, 1, 0, 32'h0000_0000);
    set_req(2, 1, 0, 32'h8000_0aa0);
    run_txn(1, 0, won);
    chk("t4_rr_advanced", bus.grant_id, 2);
    run_txn(0, 0, won);

    // Reset while L2#3's write-back is in BUSY.
    set_req(3, 0, 1, 32'h4000_0f00);
    step();
    chk("t5_busy", {bus.l3_wb_req, bus.grant_id}, {1'b1, 2'd3});
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < NUM_REQ; i++) begin m_rd[i] = 0; m_wb[i] = 0; end
    drive_reqs();
    chk("t5_rst_ctrl", {bus.l3_rd_req, bus.l3_wb_req, bus.busy, bus.timeout_err, bus.grant_id}, '0);
    chk("t5_rst_done", {bus.l2_rd_done, bus.l2_wb_done}, '0);
    chk("t5_rst_addr", bus.l3_addr, '0);
    chk("t5_rst_wb_data", bus.l3_wb_data, '0);
    chk("t5_rst_rd_data", bus.l2_rd_data, '0);
    bus.L3_ready = 1;
    bus.write_back_to_L3_verified = 1;
    step();
    bus.L3_ready = 0;
    bus.write_back_to_L3_verified = 0;
    chk("t5_late_done_ignored", {bus.l2_rd_done, bus.l2_wb_done}, '0);
    m_rr = 0; m_mask_act = 0; m_terr = 0;

    // All four read at once from rr_ptr 0: order 0,1,2,3, then wrap to 0.
    for (int i = 0; i < NUM_REQ; i++) begin
      m_rd[i] = 1; m_addr[i] = $urandom(); m_data[i] = rand_line();
    end
    drive_reqs();
    for (int k = 0; k < NUM_REQ; k++) begin
      run_txn($urandom_range(0, 2), 0, won);
      chk("t2_order", bus.grant_id, k);
    end
    set_req(3, 1, 0, 32'h1234_5678);
    set_req(0, 1, 0, 32'h8765_4320);
    run_txn(0, 0, won);
    chk("t2_wrap", bus.grant_id, 0);
    run_txn(0, 0, won);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      any = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!m_rd[i] && !m_wb[i] && $urandom_range(0, 1) == 1) begin
          cnt = $urandom_range(1, 3);
          m_rd[i] = cnt[0]; m_wb[i] = cnt[1];
          m_addr[i] = $urandom(); m_data[i] = rand_line();
        end
        if (m_rd[i] || m_wb[i]) any = 1;
      end
      drive_reqs();
      if (!any) begin
        step();
        m_mask_act = 0;
        chk("idle_no_req", {bus.l3_rd_req, bus.l3_wb_req}, 2'b00);
      end else begin
        run_txn($urandom_range(0, 5), 0, won);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
